// File: rtl/lx_port_arbiter.sv
// lx_port_arbiter
//   N-port front end for a shared Lx cache controller. It takes one whole-line
//   request at a time from NUM_PORTS requesters, forwards it to the controller,
//   captures the controller's response and returns it to the requester that
//   issued it. Arbitration is round-robin (ARB_MODE=0) or fixed priority with
//   port 0 highest (ARB_MODE=1).
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   port_msg_in   [N*M]   per-port request message (0 = no request)
//   port_address_in[N*A]  per-port request address
//   port_data_in  [N*C]   per-port request line
//   port_*_out            per-port response, non-zero only for the granted
//                         port while in RESPOND
//   cache_*_out           request to the controller, non-zero only in ISSUE
//   cache_*_in            response from the controller (msg != 0 = valid)
//   grant                 index of the port being served
//   busy                  high while a transaction is in ISSUE or RESPOND
//
// Every output is taken from flops or decoded from flopped state, so there is
// no combinational input-to-output path.

// Per-port output gate: presents the response latch only when selected.
module lx_port_arbiter_lane #(
  parameter int MSG_BITS     = 4,
  parameter int ADDRESS_BITS = 32,
  parameter int CACHE_WIDTH  = 128
) (
  input  logic                    sel,
  input  logic [MSG_BITS-1:0]     rsp_msg,
  input  logic [ADDRESS_BITS-1:0] rsp_address,
  input  logic [CACHE_WIDTH-1:0]  rsp_data,
  output logic [MSG_BITS-1:0]     msg_out,
  output logic [ADDRESS_BITS-1:0] address_out,
  output logic [CACHE_WIDTH-1:0]  data_out
);
  assign msg_out     = sel ? rsp_msg     : '0;
  assign address_out = sel ? rsp_address : '0;
  assign data_out    = sel ? rsp_data    : '0;
endmodule

module lx_port_arbiter #(
  parameter int NUM_PORTS         = 2,
  parameter int DATA_WIDTH        = 32,
  parameter int CACHE_OFFSET_BITS = 2,
  parameter int CACHE_WIDTH       = DATA_WIDTH << CACHE_OFFSET_BITS,
  parameter int ADDRESS_BITS      = 32,
  parameter int MSG_BITS          = 4,
  parameter int ARB_MODE          = 0,
  parameter int PORT_BITS         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_PORTS*MSG_BITS-1:0]     port_msg_in,
  input  logic [NUM_PORTS*ADDRESS_BITS-1:0] port_address_in,
  input  logic [NUM_PORTS*CACHE_WIDTH-1:0]  port_data_in,
  output logic [NUM_PORTS*MSG_BITS-1:0]     port_msg_out,
  output logic [NUM_PORTS*ADDRESS_BITS-1:0] port_address_out,
  output logic [NUM_PORTS*CACHE_WIDTH-1:0]  port_data_out,
  output logic [MSG_BITS-1:0]               cache_msg_out,
  output logic [ADDRESS_BITS-1:0]           cache_address_out,
  output logic [CACHE_WIDTH-1:0]            cache_data_out,
  input  logic [MSG_BITS-1:0]               cache_msg_in,
  input  logic [ADDRESS_BITS-1:0]           cache_address_in,
  input  logic [CACHE_WIDTH-1:0]            cache_data_in,
  output logic [PORT_BITS-1:0]              grant,
  output logic                              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;

  // Packed per-port views of the flattened buses; element p is slice p.
  logic [NUM_PORTS-1:0][MSG_BITS-1:0]     pmsg;
  logic [NUM_PORTS-1:0][ADDRESS_BITS-1:0] paddr;
  logic [NUM_PORTS-1:0][CACHE_WIDTH-1:0]  pdata;
  logic [NUM_PORTS-1:0][MSG_BITS-1:0]     pmsg_o;
  logic [NUM_PORTS-1:0][ADDRESS_BITS-1:0] paddr_o;
  logic [NUM_PORTS-1:0][CACHE_WIDTH-1:0]  pdata_o;
  logic [NUM_PORTS-1:0]                   pend;

  assign pmsg  = port_msg_in;
  assign paddr = port_address_in;
  assign pdata = port_data_in;

  state_t                  state_q, state_d;
  logic [PORT_BITS-1:0]    grant_q, grant_d;
  logic [PORT_BITS-1:0]    rr_ptr_q, rr_ptr_d;
  logic [MSG_BITS-1:0]     req_msg_q, req_msg_d;
  logic [ADDRESS_BITS-1:0] req_addr_q, req_addr_d;
  logic [CACHE_WIDTH-1:0]  req_data_q, req_data_d;
  logic [MSG_BITS-1:0]     rsp_msg_q, rsp_msg_d;
  logic [ADDRESS_BITS-1:0] rsp_addr_q, rsp_addr_d;
  logic [CACHE_WIDTH-1:0]  rsp_data_q, rsp_data_d;

  logic [PORT_BITS-1:0]    win;
  logic                    win_vld;
  logic [PORT_BITS:0]      cand;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_pend
    assign pend[p] = |pmsg[p];
  end

  // Winner search. Candidates are visited starting at rr_ptr (round-robin) or
  // at 0 (fixed priority); the first pending one wins. cand has one spare bit
  // so rr_ptr + i cannot overflow before the modulo fold.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = (ARB_MODE == 0) ? ({1'b0, rr_ptr_q} + (PORT_BITS+1)'(i))
                             : (PORT_BITS+1)'(i);
      if (cand >= (PORT_BITS+1)'(NUM_PORTS))
        cand = cand - (PORT_BITS+1)'(NUM_PORTS);
      if (!win_vld && pend[cand[PORT_BITS-1:0]]) begin
        win_vld = 1'b1;
        win     = cand[PORT_BITS-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    req_msg_d  = req_msg_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    rsp_msg_d  = rsp_msg_q;
    rsp_addr_d = rsp_addr_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d    = win;
          req_msg_d  = pmsg[win];
          req_addr_d = paddr[win];
          req_data_d = pdata[win];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        // Port inputs are not looked at here: the latched request stands.
        if (|cache_msg_in) begin
          rsp_msg_d  = cache_msg_in;
          rsp_addr_d = cache_address_in;
          rsp_data_d = cache_data_in;
          state_d    = RESPOND;
        end
      end
      RESPOND: begin
        if (~|pmsg[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == PORT_BITS'(NUM_PORTS-1)) ? '0
                                                          : grant_q + PORT_BITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      req_msg_q  <= '0;
      req_addr_q <= '0;
      req_data_q <= '0;
      rsp_msg_q  <= '0;
      rsp_addr_q <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      req_msg_q  <= req_msg_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      rsp_msg_q  <= rsp_msg_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign cache_msg_out     = (state_q == ISSUE) ? req_msg_q  : '0;
  assign cache_address_out = (state_q == ISSUE) ? req_addr_q : '0;
  assign cache_data_out    = (state_q == ISSUE) ? req_data_q : '0;
  assign grant             = grant_q;
  assign busy              = (state_q != IDLE);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    lx_port_arbiter_lane #(
      .MSG_BITS    (MSG_BITS),
      .ADDRESS_BITS(ADDRESS_BITS),
      .CACHE_WIDTH (CACHE_WIDTH)
    ) u_lane (
      .sel        ((state_q == RESPOND) && (grant_q == PORT_BITS'(p))),
      .rsp_msg    (rsp_msg_q),
      .rsp_address(rsp_addr_q),
      .rsp_data   (rsp_data_q),
      .msg_out    (pmsg_o[p]),
      .address_out(paddr_o[p]),
      .data_out   (pdata_o[p])
    );
  end

  assign port_msg_out     = pmsg_o;
  assign port_address_out = paddr_o;
  assign port_data_out    = pdata_o;

endmodule

// File: tb/tb_lx_port_arbiter.sv
// Bench for lx_port_arbiter: a round-robin and a fixed-priority instance, both
// with three ports. Expected grants are queued as stimulus is set up; serve()
// pops one per transaction, plays the cache controller and checks both sides.
module tb_lx_port_arbiter;
  localparam int NP = 3, MB = 4, AB = 32, DW = 32, OB = 2, PB = 2;
  localparam int CW = DW << OB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NP*MB-1:0] pmi [2];
  logic [NP*AB-1:0] pai [2];
  logic [NP*CW-1:0] pdi [2];
  logic [NP*MB-1:0] pmo [2];
  logic [NP*AB-1:0] pao [2];
  logic [NP*CW-1:0] pdo [2];
  logic [MB-1:0]    cmo [2], cmi [2];
  logic [AB-1:0]    cao [2], cai [2];
  logic [CW-1:0]    cdo [2], cdi [2];
  logic [PB-1:0]    gnt [2];
  logic             bsy [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    lx_port_arbiter #(
      .NUM_PORTS(NP), .DATA_WIDTH(DW), .CACHE_OFFSET_BITS(OB),
      .ADDRESS_BITS(AB), .MSG_BITS(MB), .ARB_MODE(k)
    ) u_dut (
      .clock(clk), .reset(rst),
      .port_msg_in(pmi[k]), .port_address_in(pai[k]), .port_data_in(pdi[k]),
      .port_msg_out(pmo[k]), .port_address_out(pao[k]), .port_data_out(pdo[k]),
      .cache_msg_out(cmo[k]), .cache_address_out(cao[k]), .cache_data_out(cdo[k]),
      .cache_msg_in(cmi[k]), .cache_address_in(cai[k]), .cache_data_in(cdi[k]),
      .grant(gnt[k]), .busy(bsy[k])
    );
  end

  typedef struct {
    int port;   // expected grant
    int lat;    // cycles in ISSUE before the controller answers
    bit rereq;  // requester raises its msg again after being served
    bit wdraw;  // requester withdraws its msg right after the grant
  } txn_t;

  txn_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [MB-1:0] req_msg(input int p);
    return MB'(p + 1);
  endfunction
  function automatic logic [AB-1:0] req_addr(input int p);
    return AB'(32'h100 * (p + 1));
  endfunction
  function automatic logic [CW-1:0] req_data(input int p);
    return {4{32'hD000_0000 | 32'(p)}};
  endfunction
  function automatic logic [CW-1:0] rsp_data(input logic [AB-1:0] a);
    return {a, ~a, a ^ 32'hA5A5_A5A5, 32'h0000_00A5};
  endfunction

  task automatic set_req(input int k, input int p);
    pmi[k][p*MB +: MB] = req_msg(p);
    pai[k][p*AB +: AB] = req_addr(p);
    pdi[k][p*CW +: CW] = req_data(p);
  endtask
  task automatic clr_req(input int k, input int p);
    pmi[k][p*MB +: MB] = '0;
  endtask

  // One full transaction on instance k, expected to enter ISSUE on the first
  // edge after the caller's last stimulus change.
  task automatic serve(input int k);
    txn_t t;
    int n;
    logic [AB-1:0] a;
    logic [NP*MB-1:0] em;
    logic [NP*AB-1:0] ea;
    logic [NP*CW-1:0] ed;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    t = sb.pop_front();
    a = req_addr(t.port);
    n = 0;
    do begin @(negedge clk); n++; end while (cmo[k] == '0 && n < 20);
    chk("issue_lat", n, 1);
    chk("grant", gnt[k], t.port);
    chk("busy_issue", bsy[k], 1);
    chk("cache_msg", cmo[k], req_msg(t.port));
    chk("cache_addr", cao[k], a);
    chk("cache_data", cdo[k], req_data(t.port));
    chk("port_out_issue", pmo[k], 0);
    if (t.wdraw) begin
      clr_req(k, t.port);
      pai[k][t.port*AB +: AB] = 32'hDEAD_BEEF;
    end
    repeat (t.lat) begin
      @(negedge clk);
      chk("cache_addr_hold", cao[k], a);
      chk("cache_msg_hold", cmo[k], req_msg(t.port));
    end
    cmi[k] = 4'd5; cai[k] = a; cdi[k] = rsp_data(a);
    @(negedge clk);
    cmi[k] = '0; cai[k] = '0; cdi[k] = '0;
    em = '0; em[t.port*MB +: MB] = 4'd5;
    ea = '0; ea[t.port*AB +: AB] = a;
    ed = '0; ed[t.port*CW +: CW] = rsp_data(a);
    chk("rsp_msg", pmo[k], em);
    chk("rsp_addr", pao[k], ea);
    chk("rsp_data", pdo[k], ed);
    chk("cache_msg_rsp", cmo[k], 0);
    chk("busy_rsp", bsy[k], 1);
    if (!t.wdraw) begin
      // Requester still holds its msg, so the response must stay up.
      @(negedge clk);
      chk("rsp_hold", pmo[k], em);
      clr_req(k, t.port);
    end
    @(negedge clk);
    chk("port_msg_idle", pmo[k], 0);
    chk("busy_idle", bsy[k], 0);
    if (t.rereq) set_req(k, t.port);
  endtask

  task automatic chk_zero(input int k, input string tag);
    chk({tag, "_busy"}, bsy[k], 0);
    chk({tag, "_grant"}, gnt[k], 0);
    chk({tag, "_cmsg"}, cmo[k], 0);
    chk({tag, "_caddr"}, cao[k], 0);
    chk({tag, "_pmsg"}, pmo[k], 0);
    chk({tag, "_pdata"}, pdo[k], 0);
  endtask

  initial begin
    logic [NP*MB-1:0] v;
    for (int k = 0; k < 2; k++) begin
      pmi[k] = '0; pai[k] = '0; pdi[k] = '0;
      cmi[k] = '0; cai[k] = '0; cdi[k] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero(0, "rst_rr");
    chk_zero(1, "rst_fp");
    rst = 1'b0;

    // Single requester on port 1, controller answers after two ISSUE cycles.
    sb.push_back('{port:1, lat:2, rereq:0, wdraw:0});
    set_req(0, 1);
    serve(0);

    // All three request continuously (pointer now at 2), then port 1 stops
    // re-requesting so only 0 and 2 remain and the pointer must wrap.
    sb.push_back('{port:2, lat:1, rereq:1, wdraw:0});
    sb.push_back('{port:0, lat:2, rereq:1, wdraw:0});
    sb.push_back('{port:1, lat:1, rereq:0, wdraw:0});
    sb.push_back('{port:2, lat:0, rereq:1, wdraw:0});
    sb.push_back('{port:0, lat:1, rereq:1, wdraw:0});
    sb.push_back('{port:2, lat:2, rereq:0, wdraw:0});
    sb.push_back('{port:0, lat:1, rereq:0, wdraw:0});
    set_req(0, 0); set_req(0, 1); set_req(0, 2);
    repeat (7) serve(0);

    // Withdrawal during ISSUE, then an answer in the first ISSUE cycle.
    sb.push_back('{port:0, lat:3, rereq:0, wdraw:1});
    set_req(0, 0);
    serve(0);
    sb.push_back('{port:1, lat:0, rereq:0, wdraw:0});
    set_req(0, 1);
    serve(0);

    // Reset in ISSUE: pointer is 2, so port 2 wins first; after reset the
    // lowest pending port (1) must win.
    set_req(0, 1); set_req(0, 2);
    @(negedge clk);
    chk("pre_rst_grant", gnt[0], 2);
    chk("pre_rst_busy", bsy[0], 1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero(0, "rst_issue");
    rst = 1'b0;
    sb.push_back('{port:1, lat:1, rereq:0, wdraw:0});
    sb.push_back('{port:2, lat:1, rereq:0, wdraw:0});
    serve(0);
    serve(0);

    // Reset in RESPOND drops the response without delivering more of it.
    set_req(0, 1);
    @(negedge clk);
    chk("rsp_rst_grant", gnt[0], 1);
    cmi[0] = 4'd5; cai[0] = req_addr(1); cdi[0] = rsp_data(req_addr(1));
    @(negedge clk);
    cmi[0] = '0; cai[0] = '0; cdi[0] = '0;
    v = '0; v[MB +: MB] = 4'd5;
    chk("rsp_rst_pre", pmo[0], v);
    set_req(0, 2);
    rst = 1'b1;
    @(negedge clk);
    chk_zero(0, "rst_rsp");
    rst = 1'b0;
    sb.push_back('{port:1, lat:2, rereq:0, wdraw:0});
    sb.push_back('{port:2, lat:1, rereq:0, wdraw:0});
    serve(0);
    serve(0);

    // Fixed priority: port 0 keeps winning while it re-requests; port 2 only
    // after port 0 goes away. Then 1 beats 2 when both arrive together.
    sb.push_back('{port:0, lat:1, rereq:1, wdraw:0});
    sb.push_back('{port:0, lat:2, rereq:1, wdraw:0});
    sb.push_back('{port:0, lat:0, rereq:0, wdraw:0});
    sb.push_back('{port:2, lat:1, rereq:0, wdraw:0});
    set_req(1, 0); set_req(1, 2);
    repeat (4) serve(1);
    sb.push_back('{port:1, lat:1, rereq:0, wdraw:0});
    sb.push_back('{port:2, lat:1, rereq:0, wdraw:0});
    set_req(1, 2); set_req(1, 1);
    repeat (2) serve(1);

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/lx_port_arbiter.md
# lx_port_arbiter

Parametrised N-port front end for a shared Lx cache controller. Sits between `NUM_PORTS` upstream requesters (L1 bus interfaces or core-side ports) and the single request port of an Lx cache controller. It latches one whole-line request at a time, forwards it to the controller, captures the controller's response and returns it to the requester that issued it. Arbitration is round-robin or fixed-priority, selected by parameter.

## Interface
- `NUM_PORTS`, 2, number of upstream requesters (≥1)
- `DATA_WIDTH`, 32, word width
- `CACHE_OFFSET_BITS`, 2, log2 words per line; `CACHE_WIDTH = DATA_WIDTH << CACHE_OFFSET_BITS`
- `ADDRESS_BITS`, 32, address width
- `MSG_BITS`, 4, message width; value 0 is NO_REQ
- `ARB_MODE`, 0, 0 = round-robin, 1 = fixed priority (port 0 highest)
- `PORT_BITS`, log2(NUM_PORTS) (min 1), grant index width
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `port_msg_in`  in  NUM_PORTS*MSG_BITS  per-port request message; port p occupies bits [p*MSG_BITS +: MSG_BITS]
- `port_address_in`  in  NUM_PORTS*ADDRESS_BITS  per-port request address
- `port_data_in`  in  NUM_PORTS*CACHE_WIDTH  per-port request line data
- `port_msg_out`  out  NUM_PORTS*MSG_BITS  per-port response message
- `port_address_out`  out  NUM_PORTS*ADDRESS_BITS  per-port response address
- `port_data_out`  out  NUM_PORTS*CACHE_WIDTH  per-port response data
- `cache_msg_out`/`cache_address_out`/`cache_data_out`  out  MSG_BITS/ADDRESS_BITS/CACHE_WIDTH  request to controller
- `cache_msg_in`/`cache_address_in`/`cache_data_in`  in  MSG_BITS/ADDRESS_BITS/CACHE_WIDTH  response from controller
- `grant`  out  PORT_BITS  index of the port currently served
- `busy`  out  1  high in ISSUE or RESPOND

## Operation
- States: IDLE, ISSUE, RESPOND.
- IDLE: the pending vector is bit p = (port p msg != 0). If the vector is non-zero, select the winner, register its msg, address and data into the request latch, load `grant`, and go to ISSUE. Otherwise stay in IDLE.
- Round-robin: the winner is the first pending port at index ≥ `rr_ptr`, wrapping modulo NUM_PORTS. On leaving RESPOND, `rr_ptr` = grant+1, wrapping from NUM_PORTS-1 to 0. Fixed priority: the winner is the lowest pending index, and `rr_ptr` is unused.
- ISSUE: `cache_*_out` drive the latched request. Port inputs are ignored, so changes or withdrawal after the grant have no effect. When `cache_msg_in` != 0, capture msg, address and data into the response latch, drive `cache_msg_out` = 0 from the next cycle, and go to RESPOND.
- RESPOND: the granted port's `port_*_out` drive the response latch. All other ports output 0. When the granted port's `port_msg_in` == 0, go to IDLE.
- Outside RESPOND, all `port_*_out` are 0. Outside ISSUE, `cache_*_out` are 0.
- Reset (any state, including mid-transaction): state IDLE, `rr_ptr` 0, `grant` 0, `busy` 0, all latches and all outputs 0. An in-flight transaction is dropped without a response.

## Timing
- All outputs are registered, or decoded from registered state only. There is no combinational path from any input to any output.
- Request visible in IDLE at cycle t → `cache_msg_out` valid at t+1.
- `cache_msg_in` != 0 at cycle r → `port_msg_out` valid and `cache_msg_out` = 0 at r+1.
- Requester drops its msg at cycle d → `port_msg_out` = 0 and state IDLE at d+1. The earliest next grant is at d+2.
- Minimum transaction length is 3 cycles. There is no back-to-back grant without an intervening IDLE cycle.
- If the controller responds in the first ISSUE cycle (r = t+1), that is legal and is handled identically.
- If the requester is already NO_REQ in the first RESPOND cycle, the response is presented for exactly one cycle.
- Simultaneous requests resolve in a single IDLE cycle. A port that loses arbitration keeps its request pending.

## Test plan
- Single port, NUM_PORTS=2: port1 msg=1, addr=0x100. Cache responds msg=5, data=0xA5 two cycles later → `port_msg_out`[1]=5, data 0xA5 one cycle later, `grant`=1, port0 outputs stay 0.
- Round-robin, NUM_PORTS=4: all four ports request continuously → grants 0,1,2,3,0 in order, each separated by IDLE, no starvation.
- ARB_MODE=1: ports 0 and 2 hold requests → port 0 is served repeatedly and port 2 is served only after port 0 drops.
- Port withdraws its msg during ISSUE → the latched request stays on `cache_*_out` and the response is still delivered in RESPOND.
- Reset asserted in ISSUE and in RESPOND → next cycle all outputs 0, `busy`=0, state IDLE, and the next grant goes to the lowest pending port.
- `rr_ptr` wrap: with NUM_PORTS=3, after serving port 2 with ports 0 and 2 pending → port 0 is granted next.
